// File: rtl/sw_led_regs.sv
// Memory-mapped LED / 7-segment / switch / timer register block for the I/O bridge.
// Reads respond one cycle after the request; writes take effect on the next cycle.
module sw_led_regs #(
  parameter int unsigned DB_LIMIT = 10000,
  parameter int unsigned DB_CNT_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [4:0]  addr,
  input  logic [31:0] wdata,
  output logic        rvalid,
  output logic [31:0] rdata,
  input  logic [7:0]  local_switch,
  output logic [15:0] local_leds,
  output logic [7:0]  local_num_data
);

  localparam logic [2:0] REG_LED    = 3'd0;
  localparam logic [2:0] REG_NUM    = 3'd1;
  localparam logic [2:0] REG_SWITCH = 3'd2;
  localparam logic [2:0] REG_EDGE   = 3'd3;
  localparam logic [2:0] REG_TIMER  = 3'd4;

  localparam logic [DB_CNT_W-1:0] DB_LAST = DB_CNT_W'(DB_LIMIT - 1);

  logic [7:0]          sw_s1;
  logic [7:0]          sw_s2;
  logic [7:0]          sw_db;
  logic [7:0]          sw_edge;
  logic [DB_CNT_W-1:0] db_cnt;
  logic [31:0]         timer;

  logic [2:0]  sel_c;
  logic        wr_c;
  logic        rd_c;
  logic [31:0] rd_mux_c;
  logic        db_stable_c;
  logic        db_done_c;
  logic [7:0]  edge_set_c;
  logic [7:0]  edge_clr_c;
  logic        unused_addr;

  assign sel_c       = addr[4:2];
  assign wr_c        = req & we;
  assign rd_c        = req & ~we;
  assign unused_addr = ^addr[1:0];

  // Read mux sees register contents before this cycle's write lands.
  always_comb begin
    rd_mux_c = 32'h0;
    case (sel_c)
      REG_LED:    rd_mux_c = {16'h0, local_leds};
      REG_NUM:    rd_mux_c = {24'h0, local_num_data};
      REG_SWITCH: rd_mux_c = {24'h0, sw_db};
      REG_EDGE:   rd_mux_c = {24'h0, sw_edge};
      REG_TIMER:  rd_mux_c = timer;
      default:    rd_mux_c = 32'h0;
    endcase
  end

  // Whole-byte debounce: only a return to sw_db restarts the count.
  always_comb begin
    db_stable_c = (sw_s2 == sw_db);
    db_done_c   = !db_stable_c && (db_cnt == DB_LAST);
    edge_set_c  = db_done_c ? (sw_db ^ sw_s2) : 8'h00;
    edge_clr_c  = (wr_c && (sel_c == REG_EDGE)) ? wdata[7:0] : 8'h00;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rvalid         <= 1'b0;
      rdata          <= 32'h0;
      local_leds     <= 16'h0;
      local_num_data <= 8'h0;
      sw_s1          <= 8'h0;
      sw_s2          <= 8'h0;
      sw_db          <= 8'h0;
      sw_edge        <= 8'h0;
      db_cnt         <= '0;
      timer          <= 32'h0;
    end else begin
      rvalid <= rd_c;
      if (rd_c) rdata <= rd_mux_c;

      if (wr_c && (sel_c == REG_LED)) local_leds <= wdata[15:0];
      if (wr_c && (sel_c == REG_NUM)) local_num_data <= wdata[7:0];

      if (wr_c && (sel_c == REG_TIMER)) timer <= wdata;
      else                              timer <= timer + 32'd1;

      sw_s1 <= local_switch;
      sw_s2 <= sw_s1;

      if (db_stable_c) begin
        db_cnt <= '0;
      end else if (db_done_c) begin
        db_cnt <= '0;
        sw_db  <= sw_s2;
      end else begin
        db_cnt <= db_cnt + DB_CNT_W'(1);
      end

      // A new edge beats a same-cycle write-1-to-clear.
      sw_edge <= (sw_edge & ~edge_clr_c) | edge_set_c;
    end
  end

endmodule

// File: tb/tb_sw_led_regs.sv
// Self-checking bench for sw_led_regs with DB_LIMIT=4: vector table plus scoreboarded sequences.
module tb_sw_led_regs;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        we;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic        rvalid;
  logic [31:0] rdata;
  logic [7:0]  local_switch;
  logic [15:0] local_leds;
  logic [7:0]  local_num_data;

  always #5 clk = ~clk;

  sw_led_regs #(.DB_LIMIT(4), .DB_CNT_W(16)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rvalid(rvalid), .rdata(rdata), .local_switch(local_switch),
    .local_leds(local_leds), .local_num_data(local_num_data)
  );

  localparam logic [4:0] A_LED = 5'h00, A_NUM = 5'h04, A_SW = 5'h08, A_EDGE = 5'h0C, A_TMR = 5'h10;

  typedef struct {
    logic        w;
    logic [4:0]  a;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_rdata = 32'h0;
  logic [15:0] exp_leds = 16'h0;
  logic [7:0]  exp_num = 8'h0;
  vec_t        vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, score the response captured at this edge, check outputs.
  task automatic step(input logic rst, input logic r, input logic w, input logic [4:0] a,
                      input logic [31:0] d, input logic [31:0] exp);
    logic [31:0] e;
    reset = rst; req = r; we = w; addr = a; wdata = d;
    if (r && !w && !rst) exp_q.push_back(exp);
    if (rst) begin
      exp_leds = 16'h0; exp_num = 8'h0;
    end else if (r && w && a[4:2] == 3'd0) begin
      exp_leds = d[15:0];
    end else if (r && w && a[4:2] == 3'd1) begin
      exp_num = d[7:0];
    end
    @(posedge clk);
    #1;
    if (rst) last_rdata = 32'h0;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("rvalid_hi", 32'(rvalid), 32'd1);
      check("rdata", rdata, e);
      last_rdata = e;
    end else begin
      check("rvalid_lo", 32'(rvalid), 32'd0);
      check("rdata_hold", rdata, last_rdata);
    end
    check("leds", 32'(local_leds), 32'(exp_leds));
    check("num", 32'(local_num_data), 32'(exp_num));
    reset = 1'b0; req = 1'b0; we = 1'b0;
  endtask

  initial begin
    reset = 1'b1; req = 1'b0; we = 1'b0; addr = 5'h0; wdata = 32'h0; local_switch = 8'h00;

    vecs[0]  = '{1'b1, A_LED,  32'hABCD1234, 32'h0};
    vecs[1]  = '{1'b0, A_LED,  32'h0,        32'h00001234};
    vecs[2]  = '{1'b1, A_NUM,  32'hFFFF01A5, 32'h0};
    vecs[3]  = '{1'b0, A_NUM,  32'h0,        32'h000000A5};
    vecs[4]  = '{1'b1, A_SW,   32'h000000FF, 32'h0};
    vecs[5]  = '{1'b0, A_SW,   32'h0,        32'h0};
    vecs[6]  = '{1'b1, 5'h14,  32'h12345678, 32'h0};
    vecs[7]  = '{1'b0, 5'h14,  32'h0,        32'h0};
    vecs[8]  = '{1'b0, 5'h1C,  32'h0,        32'h0};
    vecs[9]  = '{1'b0, 5'h03,  32'h0,        32'h00001234};
    vecs[10] = '{1'b1, 5'h01,  32'hFFFF5AA5, 32'h0};
    vecs[11] = '{1'b0, A_EDGE, 32'h0,        32'h0};
    vecs[12] = '{1'b0, A_LED,  32'h0,        32'h00005AA5};

    // Reset, idle three cycles, then the timer reads 3.
    step(1, 0, 0, A_LED, 0, 0);
    step(1, 0, 0, A_LED, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, A_LED, 0, 0);
    step(0, 1, 0, A_TMR, 0, 32'd3);
    step(0, 0, 0, A_LED, 0, 0);

    // Register map vectors.
    foreach (vecs[i]) step(0, 1, vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].exp);
    step(0, 0, 0, A_LED, 0, 0);

    // Three-cycle glitch never reaches the accept count.
    for (int i = 0; i < 10; i++) begin
      local_switch = (i < 3) ? 8'h01 : 8'h00;
      step(0, 1, 0, A_SW, 0, 32'h0);
    end
    step(0, 1, 0, A_EDGE, 0, 32'h0);

    // Clean change is visible to a read issued 6 edges after the switch moves.
    local_switch = 8'h05;
    for (int i = 0; i < 6; i++) step(0, 1, 0, A_SW, 0, 32'h0);
    step(0, 1, 0, A_SW, 0, 32'h05);
    step(0, 1, 0, A_EDGE, 0, 32'h05);
    step(0, 1, 1, A_EDGE, 32'hFFFFFF05, 0);
    step(0, 1, 0, A_EDGE, 0, 32'h0);

    // Bit 0 falls; clear it on the very edge the debouncer sets it.
    local_switch = 8'h04;
    for (int i = 0; i < 5; i++) step(0, 1, 0, A_SW, 0, 32'h05);
    step(0, 1, 1, A_EDGE, 32'h01, 0);
    step(0, 1, 0, A_EDGE, 0, 32'h01);
    step(0, 1, 0, A_SW, 0, 32'h04);
    step(0, 1, 1, A_EDGE, 32'h05, 0);
    step(0, 1, 0, A_EDGE, 0, 32'h0);

    // Timer load and wrap.
    step(0, 1, 1, A_TMR, 32'hFFFFFFFE, 0);
    step(0, 1, 0, A_TMR, 0, 32'hFFFFFFFE);
    step(0, 1, 0, A_TMR, 0, 32'hFFFFFFFF);
    step(0, 1, 0, A_TMR, 0, 32'h00000000);

    // Reset alongside a read request: no response, registers cleared.
    step(0, 1, 1, A_NUM, 32'h3C, 0);
    step(1, 1, 0, A_TMR, 0, 0);
    step(0, 0, 0, A_LED, 0, 0);
    step(0, 1, 0, A_TMR, 0, 32'd1);
    step(0, 1, 0, A_SW, 0, 32'h0);
    step(0, 0, 0, A_LED, 0, 0);

    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sw_led_regs.md
Name: sw_led_regs

Overview:
- Small memory-mapped register block between the CPU's peripheral bus and the remote/local I/O bridge.
- Drives the 16 local LEDs and the 8-bit number shown on the two 7-segment digits.
- Samples the 8 local switches through a 2-flop synchroniser plus debouncer, and records per-switch change flags.
- Provides a free-running 32-bit timer.

Parameters:
- DB_LIMIT, 16'd10000: consecutive stable cycles required before a switch change is accepted; legal range 2..65535.
- DB_CNT_W, 16: width of the debounce counter; must hold DB_LIMIT-1.

Ports:
- clk  input  1  single system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  1  bus request valid this cycle.
- we  input  1  1 = write, 0 = read; qualified by req.
- addr  input  5  byte address; addr[4:2] selects the register, addr[1:0] is ignored.
- wdata  input  32  write data.
- rvalid  output  1  read response valid; one-cycle pulse.
- rdata  output  32  read data; meaningful only when rvalid=1.
- local_switch  input  8  switch levels from the I/O bridge; asynchronous to clk.
- local_leds  output  16  LED pattern to the I/O bridge.
- local_num_data  output  8  two hex digits to the I/O bridge; [7:4] high digit, [3:0] low digit.

Behaviour:
- Reset (reset=1 at a clk edge), all cleared to 0:
  - rvalid=0, rdata=0, local_leds=16'h0000, local_num_data=8'h00.
  - Timer, debounce counter, both synchroniser flops, debounced switch register (sw_db) and edge flags.
- Reset asserted mid-operation:
  - Aborts any pending read response (no rvalid the following cycle).
  - Clears a partially elapsed debounce count.
- Register map, by addr[4:2]:
  - 0 LED: R/W; write loads wdata[15:0]; read returns {16'b0, local_leds}.
  - 1 NUM: R/W; write loads wdata[7:0]; read returns {24'b0, local_num_data}.
  - 2 SWITCH: RO; read returns {24'b0, sw_db}; writes ignored.
  - 3 EDGE: write-1-to-clear on wdata[7:0]; read returns {24'b0, edge}.
  - 4 TIMER: R/W; read returns the current count; write loads wdata.
  - 5-7: reserved; reads return 0, writes ignored.
- Bus timing:
  - No backpressure; a request is accepted every cycle req=1.
  - Read in cycle N: rvalid=1 in cycle N+1 only, with rdata = register value sampled at the end of cycle N (pre-update).
  - Write in cycle N: the register holds the new value from cycle N+1. No response; rvalid stays 0.
  - Back-to-back requests: a write in N followed by a read of the same register in N+1 returns the written value in N+2.
  - rdata holds its last value when rvalid=0.
- Synchroniser: sw_s1 <= local_switch; sw_s2 <= sw_s1. Only sw_s2 feeds later logic.
- Debounce, whole-byte:
  - sw_s2 == sw_db: counter <= 0.
  - Otherwise, counter < DB_LIMIT-1: counter increments.
  - Otherwise, counter == DB_LIMIT-1: sw_db <= sw_s2, counter <= 0, edge <= edge | (sw_db ^ sw_s2).
  - sw_s2 changing value while unstable does not reset the count; only equality with sw_db resets it.
  - Net result: a single clean transition is accepted DB_LIMIT cycles after sw_s2 changes, i.e. DB_LIMIT+2 cycles after local_switch changes.
- Edge flags:
  - Set as above and sticky until cleared.
  - A set and a write-1-clear on the same bit in the same cycle: set wins (bit = 1).
- Timer:
  - Increments by 1 every cycle, wrapping 32'hFFFFFFFF -> 0.
  - In a write cycle the timer loads wdata instead of incrementing; it increments from the next cycle.
- Unused wdata bits are ignored.
- No X on any output after reset.

Test Plan:
- Reset then idle 3 cycles -> local_leds=0, local_num_data=0, rvalid=0; read TIMER at cycle 3 after reset -> rdata=3 the next cycle.
- Write LED=32'hABCD1234, then read LED in the next cycle -> local_leds=16'h1234 one cycle after the write; rvalid pulses once with rdata=32'h00001234.
- DB_LIMIT=4: local_switch 8'h00->8'h05 held stable -> sw_db=8'h05 exactly 6 cycles after the change; EDGE read returns 8'h05.
- DB_LIMIT=4: glitch local_switch high for 3 cycles then back -> sw_db stays 0, EDGE stays 0.
- Write EDGE=8'h01 in the same cycle that debounce sets bit 0 -> bit 0 reads 1; a later write of 8'h05 -> EDGE reads 0.
- Write TIMER=32'hFFFFFFFE, then read on each of the next 3 cycles -> rdata sequence FFFFFFFE, FFFFFFFF, 00000000; assert reset between a read request and its response -> no rvalid.
